// File: rtl/video_timing_pkg.sv
// 800x600@60 raster constants, phase encoding and a phase lookup helper
// shared by the timing generator and its counters.
package video_timing_pkg;

    localparam int HPOS_W = 11;
    localparam int VPOS_W = 10;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 40;
    localparam int H_SYNC   = 128;
    localparam int H_BP     = 88;
    localparam int V_ACTIVE = 600;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 4;
    localparam int V_BP     = 23;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic HSYNC_POL = 1'b1;
    localparam logic VSYNC_POL = 1'b1;
    localparam int   PIX_LEAD  = 2;

    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_t;

    function automatic phase_t phaseAt(input int pos, input int lenAct, input int lenFp, input int lenSync);
        if (pos < lenAct)                  return PH_ACT;
        if (pos < lenAct + lenFp)          return PH_FP;
        if (pos < lenAct + lenFp + lenSync) return PH_SYNC;
        return PH_BP;
    endfunction

endpackage

// File: rtl/sync_phase_counter.sv
// Wrapping position counter with ACT/FP/SYNC/BP phase tracking; exposes next-state values.
// Latency: count/phase update on the edge after enable; countNext/phaseNext are combinational.
// Backpressure: none, free-running whenever enable is high.
module sync_phase_counter
    import video_timing_pkg::*;
#(
    parameter int W         = 11,
    parameter int LEN_ACT   = 800,
    parameter int LEN_FP    = 40,
    parameter int LEN_SYNC  = 128,
    parameter int LEN_BP    = 88,
    parameter int RST_COUNT = 0
) (
    input  logic         clk40,
    input  logic         reset,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic [W-1:0] countNext,
    output logic [1:0]   phaseNext,
    output logic         wrap
);

    localparam int TOTAL = LEN_ACT + LEN_FP + LEN_SYNC + LEN_BP;

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] FP_AT   = W'(LEN_ACT);
    localparam logic [W-1:0] SYNC_AT = W'(LEN_ACT + LEN_FP);
    localparam logic [W-1:0] BP_AT   = W'(LEN_ACT + LEN_FP + LEN_SYNC);

    localparam logic [1:0] ST_ACT    = PH_ACT;
    localparam logic [1:0] ST_FP     = PH_FP;
    localparam logic [1:0] ST_SYNC   = PH_SYNC;
    localparam logic [1:0] ST_BP     = PH_BP;
    localparam logic [1:0] RST_PHASE = phaseAt(RST_COUNT, LEN_ACT, LEN_FP, LEN_SYNC);

    logic [1:0] phase;

    assign wrap = enable && (count == LAST);

    // Phase changes are keyed on the incoming count so the phase register lines up with count.
    always_comb begin
        countNext = count;
        phaseNext = phase;
        if (enable) begin
            countNext = wrap ? '0 : count + 1'b1;
            if (countNext == '0)          phaseNext = ST_ACT;
            else if (countNext == FP_AT)   phaseNext = ST_FP;
            else if (countNext == SYNC_AT) phaseNext = ST_SYNC;
            else if (countNext == BP_AT)   phaseNext = ST_BP;
        end
    end

    always_ff @(posedge clk40) begin
        if (reset) begin
            count <= W'(RST_COUNT);
            phase <= RST_PHASE;
        end else begin
            count <= countNext;
            phase <= phaseNext;
        end
    end

endmodule

// File: rtl/video_timing.sv
// 800x600@60 raster timing plus background-layer line controls; VIDEO_TIMING_FRAME_COUNT_EN adds frameStart/frameCount.
// Latency: every output is registered and decoded from next-state counters, so it matches hPos/vPos in the same cycle.
// Backpressure: none; the raster free-runs and consumers must keep pace.
module video_timing
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE  = video_timing_pkg::H_ACTIVE,
    parameter int   H_FP      = video_timing_pkg::H_FP,
    parameter int   H_SYNC    = video_timing_pkg::H_SYNC,
    parameter int   H_BP      = video_timing_pkg::H_BP,
    parameter int   V_ACTIVE  = video_timing_pkg::V_ACTIVE,
    parameter int   V_FP      = video_timing_pkg::V_FP,
    parameter int   V_SYNC    = video_timing_pkg::V_SYNC,
    parameter int   V_BP      = video_timing_pkg::V_BP,
    parameter logic HSYNC_POL = video_timing_pkg::HSYNC_POL,
    parameter logic VSYNC_POL = video_timing_pkg::VSYNC_POL,
    parameter int   PIX_LEAD  = video_timing_pkg::PIX_LEAD
) (
    input  logic              clk40,
    input  logic              reset,
    output logic [HPOS_W-1:0] hPos,
    output logic [VPOS_W-1:0] vPos,
    output logic [VPOS_W-1:0] nextVPos,
    output logic              hsync,
    output logic              vsync,
    output logic              displayActive,
    output logic              hsyncStarting,
    output logic              nextFrameActive,
    output logic              lineStarting,
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    output logic              frameStart,
    output logic [15:0]       frameCount,
`endif
    output logic              lineEnding
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 2047) begin : gHTotalTooBig
        $error("H_TOTAL does not fit the 11-bit horizontal counter");
    end
    if (V_TOTAL > 1023) begin : gVTotalTooBig
        $error("V_TOTAL does not fit the 10-bit vertical counter");
    end

    localparam logic [HPOS_W-1:0] HSS_AT    = HPOS_W'(H_ACTIVE + H_FP);
    localparam logic [HPOS_W-1:0] LS_AT     = HPOS_W'(H_TOTAL - PIX_LEAD);
    localparam logic [HPOS_W-1:0] LE_AT     = HPOS_W'(H_ACTIVE - PIX_LEAD);
    localparam logic [VPOS_W-1:0] V_LAST    = VPOS_W'(V_TOTAL - 1);
    localparam logic [VPOS_W-1:0] V_ACT_LIM = VPOS_W'(V_ACTIVE);

    logic [HPOS_W-1:0] hNext;
    logic [VPOS_W-1:0] vNext;
    logic [VPOS_W-1:0] vAfter;
    logic [1:0]        hPhNext;
    logic [1:0]        vPhNext;
    logic              hWrap;
    logic              vWrap;

    sync_phase_counter #(
        .W(HPOS_W), .LEN_ACT(H_ACTIVE), .LEN_FP(H_FP), .LEN_SYNC(H_SYNC), .LEN_BP(H_BP), .RST_COUNT(0)
    ) uHCounter (
        .clk40(clk40), .reset(reset), .enable(1'b1),
        .count(hPos), .countNext(hNext), .phaseNext(hPhNext), .wrap(hWrap)
    );

    // Reset parks the raster at the first blanking line so the first visible line is line 0.
    sync_phase_counter #(
        .W(VPOS_W), .LEN_ACT(V_ACTIVE), .LEN_FP(V_FP), .LEN_SYNC(V_SYNC), .LEN_BP(V_BP), .RST_COUNT(V_ACTIVE)
    ) uVCounter (
        .clk40(clk40), .reset(reset), .enable(hWrap),
        .count(vPos), .countNext(vNext), .phaseNext(vPhNext), .wrap(vWrap)
    );

    assign vAfter = (vNext == V_LAST) ? '0 : vNext + 1'b1;

    always_ff @(posedge clk40) begin
        if (reset) begin
            nextVPos        <= VPOS_W'(V_ACTIVE + 1);
            hsync           <= ~HSYNC_POL;
            vsync           <= ~VSYNC_POL;
            displayActive   <= 1'b0;
            hsyncStarting   <= 1'b0;
            nextFrameActive <= 1'b0;
            lineStarting    <= 1'b0;
            lineEnding      <= 1'b0;
        end else begin
            nextVPos        <= vAfter;
            hsync           <= (hPhNext == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
            vsync           <= (vPhNext == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
            displayActive   <= (hPhNext == PH_ACT) && (vPhNext == PH_ACT);
            hsyncStarting   <= (hNext == HSS_AT);
            nextFrameActive <= (vAfter < V_ACT_LIM);
            lineStarting    <= (hNext == LS_AT) && (vAfter < V_ACT_LIM);
            lineEnding      <= (hNext == LE_AT) && (vPhNext == PH_ACT);
        end
    end

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    always_ff @(posedge clk40) begin
        if (reset) begin
            frameStart <= 1'b0;
            frameCount <= '0;
        end else begin
            frameStart <= vWrap;
            if (vWrap) frameCount <= frameCount + 16'd1;
        end
    end
`else
    logic unusedVWrap;
    assign unusedVWrap = vWrap;
`endif

endmodule

// File: tb/tb_video_timing.sv
// Directed bench for video_timing: reset state, line/frame decode positions and mid-line reset.
module tb_video_timing;

    logic        clk40 = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] hPos;
    logic [9:0]  vPos;
    logic [9:0]  nextVPos;
    logic        hsync, vsync, displayActive, hsyncStarting, nextFrameActive, lineStarting, lineEnding;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    logic        frameStart;
    logic [15:0] frameCount;
`endif

    video_timing dut (
        .clk40(clk40),
        .reset(reset),
        .hPos(hPos),
        .vPos(vPos),
        .nextVPos(nextVPos),
        .hsync(hsync),
        .vsync(vsync),
        .displayActive(displayActive),
        .hsyncStarting(hsyncStarting),
        .nextFrameActive(nextFrameActive),
        .lineStarting(lineStarting),
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
        .frameStart(frameStart),
        .frameCount(frameCount),
`endif
        .lineEnding(lineEnding)
    );

    always #5 clk40 = ~clk40;

    int checks = 0;
    int errors = 0;
    int eh = 0;
    int ev = 600;
    int badH = 0, badV = 0, badNv = 0, badHs = 0, badVs = 0;
    int badDa = 0, badHss = 0, badNfa = 0, badLs = 0, badLe = 0;
    int lsCnt = 0, leCnt = 0, hssCnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and compare every output against the raster definition at (eh, ev).
    task automatic step();
        int nv;
        @(posedge clk40);
        #1;
        if (eh == 1055) begin
            eh = 0;
            ev = (ev == 627) ? 0 : ev + 1;
        end else begin
            eh = eh + 1;
        end
        nv = (ev == 627) ? 0 : ev + 1;
        if (hPos !== 11'(eh)) badH++;
        if (vPos !== 10'(ev)) badV++;
        if (nextVPos !== 10'(nv)) badNv++;
        if (hsync !== 1'(eh >= 840 && eh <= 967)) badHs++;
        if (vsync !== 1'(ev >= 601 && ev <= 604)) badVs++;
        if (displayActive !== 1'(eh < 800 && ev < 600)) badDa++;
        if (hsyncStarting !== 1'(eh == 840)) badHss++;
        if (nextFrameActive !== 1'(nv < 600)) badNfa++;
        if (lineStarting !== 1'(eh == 1054 && nv < 600)) badLs++;
        if (lineEnding !== 1'(eh == 798 && ev < 600)) badLe++;
        if (lineStarting === 1'b1) lsCnt++;
        if (lineEnding === 1'b1) leCnt++;
        if (hsyncStarting === 1'b1) hssCnt++;
    endtask

    task automatic runTo(input int v, input int h);
        int n;
        n = 0;
        while (!(ev == v && eh == h)) begin
            step();
            n++;
            if (n > 40000) begin
                errors++;
                $display("FAIL runTo(%0d,%0d) not reached within cycle budget", v, h);
                $fatal(1, "cycle budget exhausted");
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk40);
        #1;
        chk("rst_hPos", 32'(hPos), 0);
        chk("rst_vPos", 32'(vPos), 600);
        chk("rst_nextVPos", 32'(nextVPos), 601);
        chk("rst_hsync", 32'(hsync), 0);
        chk("rst_vsync", 32'(vsync), 0);
        chk("rst_displayActive", 32'(displayActive), 0);
        chk("rst_hsyncStarting", 32'(hsyncStarting), 0);
        chk("rst_nextFrameActive", 32'(nextFrameActive), 0);
        chk("rst_lineStarting", 32'(lineStarting), 0);
        chk("rst_lineEnding", 32'(lineEnding), 0);

        reset = 1'b0;
        eh = 0;
        ev = 600;
        step();
        chk("rel_hPos", 32'(hPos), 1);
        chk("rel_vPos", 32'(vPos), 600);
        chk("rel_nextVPos", 32'(nextVPos), 601);
        chk("rel_hsync", 32'(hsync), 0);
        chk("rel_vsync", 32'(vsync), 0);

        lsCnt = 0; leCnt = 0; hssCnt = 0;
        runTo(600, 1055);
        chk("vsync_600_end", 32'(vsync), 0);
        step();
        chk("vsync_601_start", 32'(vsync), 1);
        runTo(604, 1055);
        chk("vsync_604_end", 32'(vsync), 1);
        step();
        chk("vsync_605_start", 32'(vsync), 0);
        runTo(627, 0);
        chk("nfa_627", 32'(nextFrameActive), 1);
        chk("nextVPos_627", 32'(nextVPos), 0);
        chk("ls_absent_600_626", 32'(lsCnt), 0);
        chk("le_absent_blank", 32'(leCnt), 0);
        runTo(627, 1053);
        chk("ls_627_1053", 32'(lineStarting), 0);
        step();
        chk("ls_627_1054", 32'(lineStarting), 1);
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
        force dut.frameCount = 16'hFFFF;
        step();
        release dut.frameCount;
`endif
        runTo(0, 0);
        chk("ls_once_line627", 32'(lsCnt), 1);
        chk("da_0_0", 32'(displayActive), 1);
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
        chk("frameStart_0_0", 32'(frameStart), 1);
        chk("frameCount_wrap", 32'(frameCount), 0);
        step();
        chk("frameStart_0_1", 32'(frameStart), 0);
`endif

        lsCnt = 0; leCnt = 0; hssCnt = 0;
        runTo(10, 0);
        chk("ls_count_lines0_9", 32'(lsCnt), 10);
        chk("le_count_lines0_9", 32'(leCnt), 10);
        chk("hss_count_lines0_9", 32'(hssCnt), 10);

        lsCnt = 0; leCnt = 0; hssCnt = 0;
        runTo(10, 797);
        chk("le_10_797", 32'(lineEnding), 0);
        step();
        chk("le_10_798", 32'(lineEnding), 1);
        step();
        chk("le_10_799", 32'(lineEnding), 0);
        chk("da_10_799", 32'(displayActive), 1);
        step();
        chk("da_10_800", 32'(displayActive), 0);
        runTo(10, 839);
        chk("hss_10_839", 32'(hsyncStarting), 0);
        chk("hsync_10_839", 32'(hsync), 0);
        step();
        chk("hss_10_840", 32'(hsyncStarting), 1);
        chk("hsync_10_840", 32'(hsync), 1);
        step();
        chk("hss_10_841", 32'(hsyncStarting), 0);
        runTo(10, 967);
        chk("hsync_10_967", 32'(hsync), 1);
        step();
        chk("hsync_10_968", 32'(hsync), 0);
        runTo(10, 1055);
        chk("le_count_line10", 32'(leCnt), 1);
        chk("hss_count_line10", 32'(hssCnt), 1);

        runTo(11, 797);
        reset = 1'b1;
        @(posedge clk40);
        #1;
        chk("rstmid_lineEnding", 32'(lineEnding), 0);
        chk("rstmid_hPos", 32'(hPos), 0);
        chk("rstmid_vPos", 32'(vPos), 600);
        chk("rstmid_nextVPos", 32'(nextVPos), 601);
        chk("rstmid_displayActive", 32'(displayActive), 0);
        reset = 1'b0;
        eh = 0;
        ev = 600;
        lsCnt = 0; leCnt = 0;
        runTo(602, 0);
        chk("ls_after_rstmid", 32'(lsCnt), 0);
        chk("le_after_rstmid", 32'(leCnt), 0);

        chk("trace_hPos", 32'(badH), 0);
        chk("trace_vPos", 32'(badV), 0);
        chk("trace_nextVPos", 32'(badNv), 0);
        chk("trace_hsync", 32'(badHs), 0);
        chk("trace_vsync", 32'(badVs), 0);
        chk("trace_displayActive", 32'(badDa), 0);
        chk("trace_hsyncStarting", 32'(badHss), 0);
        chk("trace_nextFrameActive", 32'(badNfa), 0);
        chk("trace_lineStarting", 32'(badLs), 0);
        chk("trace_lineEnding", 32'(badLe), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
